// File: rtl/board_store_analyzer.sv
// board_store_analyzer: row-addressed board store with column height/hole/roughness analysis; BOARD_LINE_CLEAR_EN enables full-row clearing and lines_cleared
module board_store_analyzer #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    localparam int HW = $clog2(ROWS + 1),
    localparam int SW = $clog2(ROWS * COLS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_save,
    input  logic            req_analy,
    input  logic [5:0]      row_idx,
    input  logic [COLS-1:0] row_info,
`ifdef BOARD_LINE_CLEAR_EN
    output logic [5:0]      lines_cleared,
`endif
    output logic            ready,
    output logic            resp,
    output logic            err,
    output logic [HW-1:0]   max_height,
    output logic [HW-1:0]   min_height,
    output logic [SW-1:0]   cum_height,
    output logic [HW-1:0]   rel_height,
    output logic [SW-1:0]   roughness,
    output logic [SW-1:0]   hole_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam int CW = $clog2(COLS);
    localparam logic [CW-1:0] LAST = CW'(COLS - 1);
    localparam logic [5:0] ROWS6 = 6'(ROWS);

    state_t state, state_nx;
    logic [COLS-1:0] board [ROWS];
    logic [CW-1:0] col;
    logic [HW-1:0] h_col, n_ones, prev_h, diff, acc_max, acc_min;
    logic [SW-1:0] acc_cum, acc_rough, acc_holes;
    logic save_acc, save_ok, analy_acc, clr;

    assign ready = state == IDLE;
    assign save_acc = ready & req_save;
    assign save_ok = save_acc & (row_idx < ROWS6);
    assign analy_acc = ready & req_analy & ~req_save;

`ifdef BOARD_LINE_CLEAR_EN
    assign clr = save_ok & (&row_info);
    // count cleared lines, saturating at 63
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lines_cleared <= '0;
        else if (clr && lines_cleared != 6'd63) lines_cleared <= lines_cleared + 1'b1;
`else
    assign clr = 1'b0;
`endif

    // board storage: plain row write, or collapse of rows at/above row_idx on a full-row clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) board[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (clr && 6'(r) >= row_idx) board[r] <= (r == ROWS - 1) ? '0 : board[(r + 1) % ROWS];
                else if (save_ok && !clr && row_idx == 6'(r)) board[r] <= row_info;
        end

    // height of the column under scan; holes are the cells below the top that are not filled
    always_comb begin
        h_col = '0;
        n_ones = '0;
        for (int r = 0; r < ROWS; r++)
            if (board[r][col]) begin
                h_col = HW'(r + 1);
                n_ones = n_ones + 1'b1;
            end
        diff = (col == '0) ? '0 : (h_col > prev_h) ? h_col - prev_h : prev_h - h_col;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // next state: one column per SCAN cycle, then a single DONE cycle
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (analy_acc ? SCAN : IDLE) :
                   (state == SCAN) ? ((col == LAST) ? DONE : SCAN) : IDLE;
    end

    // scan accumulators, cleared when an analysis is accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            prev_h <= '0;
            acc_max <= '0;
            acc_min <= '0;
            acc_cum <= '0;
            acc_rough <= '0;
            acc_holes <= '0;
        end else if (analy_acc) begin
            col <= '0;
            prev_h <= '0;
            acc_max <= '0;
            acc_min <= HW'(ROWS);
            acc_cum <= '0;
            acc_rough <= '0;
            acc_holes <= '0;
        end else if (state == SCAN) begin
            col <= col + 1'b1;
            prev_h <= h_col;
            acc_max <= (h_col > acc_max) ? h_col : acc_max;
            acc_min <= (h_col < acc_min) ? h_col : acc_min;
            acc_cum <= acc_cum + SW'(h_col);
            acc_rough <= acc_rough + SW'(diff);
            acc_holes <= acc_holes + SW'(h_col - n_ones);
        end

    // results only change as a complete set when leaving DONE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            max_height <= '0;
            min_height <= '0;
            cum_height <= '0;
            rel_height <= '0;
            roughness <= '0;
            hole_count <= '0;
        end else if (state == DONE) begin
            max_height <= acc_max;
            min_height <= acc_min;
            cum_height <= acc_cum;
            rel_height <= acc_max - acc_min;
            roughness <= acc_rough;
            hole_count <= acc_holes;
        end

    // completion pulse for accepted saves and finished analyses
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            resp <= 1'b0;
            err <= 1'b0;
        end else begin
            resp <= save_acc | (state == DONE);
            err <= save_acc & ~save_ok;
        end
endmodule

// File: doc/board_store_analyzer.md
BOARD_STORE_ANALYZER -- requirements
Module: board_store_analyzer

Interface
REQ-001 Parameter COLS, default 10, board width in cells; legal range 2..32.
REQ-002 Parameter ROWS, default 20, board height in rows; legal range 2..63; row 0 is the bottom row.
REQ-003 Derived widths shall be HW = clog2(ROWS+1) and SW = clog2(ROWS*COLS+1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_save  in  1  save request; row_info written to row row_idx.
REQ-007 req_analy  in  1  analysis request.
REQ-008 row_idx  in  6  target row index.
REQ-009 row_info  in  COLS  row occupancy, bit c = column c (bit 0 leftmost).
REQ-010 ready  out  1  high when the block can accept a request.
REQ-011 resp  out  1  one-cycle completion pulse for a save or analysis.
REQ-012 err  out  1  valid with resp; set when a save was rejected for row_idx >= ROWS.
REQ-013 max_height  out  HW  tallest column height.
REQ-014 min_height  out  HW  shortest column height.
REQ-015 cum_height  out  SW  sum of all column heights.
REQ-016 rel_height  out  HW  max_height minus min_height.
REQ-017 roughness  out  SW  sum over c of |h[c+1]-h[c]|.
REQ-018 hole_count  out  SW  empty cells below the top filled cell of their column.

Function
REQ-019 Storage shall be a ROWS x COLS bit register array; column height h[c] = 1 + index of the highest set bit in column c, or 0 if the column is empty.
REQ-020 The FSM shall have states IDLE, SCAN and DONE; ready = 1 only in IDLE.
REQ-021 In IDLE, req_save with row_idx < ROWS: row is written at that edge; next cycle resp=1, err=0; state stays IDLE.
REQ-022 In IDLE, req_save with row_idx >= ROWS: board is unchanged; next cycle resp=1, err=1.
REQ-023 req_save and req_analy both high in IDLE: save has priority; req_analy is dropped and must be re-issued.
REQ-024 In IDLE, req_analy (without req_save): accumulators clear, column counter = 0, go to SCAN.
REQ-025 SCAN shall process one column per cycle (height, hole count, and difference against the previous column's height), taking exactly COLS cycles, then go to DONE.
REQ-026 DONE shall, in one cycle, update all six result outputs together, pulse resp=1 with err=0, and return to IDLE; total latency from req_analy edge to resp is COLS+1 cycles.
REQ-027 Result outputs shall hold their last values until the next DONE; they shall never show partial accumulations.
REQ-028 Requests while ready=0 shall be ignored with no side effects.
REQ-029 All arithmetic shall be unsigned; the rel_height subtraction cannot underflow because max >= min; accumulators are sized so they cannot overflow at any legal parameter value.
REQ-030 resp shall be high for exactly one cycle per accepted request.

Reset
REQ-031 When rst_n=0, all outputs shall go asynchronously to 0 except ready, and all board cells shall go to 0.
REQ-032 ready shall be 1 during reset and FSM state shall be IDLE.
REQ-033 Reset during SCAN shall abort the scan with no resp pulse; results stay 0.

Configuration
REQ-034 With macro BOARD_LINE_CLEAR_EN defined, an accepted save of an all-ones row shall instead shift every row above row_idx down by one and load row ROWS-1 with zeros; resp is still one cycle later, and an added 6-bit output lines_cleared shall increment (saturating at 63).
REQ-035 Without BOARD_LINE_CLEAR_EN, full rows shall be stored as given, and lines_cleared shall not exist.

Verification
REQ-036 Reset, then analyze an empty board -> resp at cycle 11 (default parameters); all results 0; ready returns to 1.
REQ-037 Save row 0 = 10'h3FF (macro off), then analyze -> max=1, min=1, cum=10, rel=0, rough=0, holes=0.
REQ-038 Save row 3 = 10'h001 only, then analyze -> h[0]=4; max=4, min=0, cum=4, rel=4, rough=4, holes=3.
REQ-039 Save with row_idx=25 -> resp=1, err=1; a subsequent analysis still reports an empty board.
REQ-040 Raise req_save and req_analy together -> save occurs, no SCAN; a req_analy during SCAN is ignored; pull rst_n low mid-SCAN -> no resp pulse, results 0.
REQ-041 Macro on: save row 0 = 10'h001, save row 1 = 10'h3FF -> row 1 cleared, lines_cleared=1; analysis gives max=1, cum=1.
